// File: rtl/sklansky_pipe_adder_pkg.sv
// Shared constants and elaboration-time helpers for the Sklansky pipelined adder.
package sklansky_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Number of prefix levels needed to span width bits.
    function automatic int unsigned clog2_levels(input int unsigned width);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < width) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

    // True when a register follows step idx (prefix levels 0..levels-1, sum XOR = levels).
    // Registers are spread evenly; the final step always gets one.
    function automatic logic stage_flag(input int unsigned idx, input int unsigned pipe,
                                        input int unsigned levels);
        return ((idx + 1) * pipe) / (levels + 1) > (idx * pipe) / (levels + 1);
    endfunction

endpackage

// File: rtl/sklansky_pipe_adder_if.sv
// Operand/result handshake bundle for the Sklansky pipelined adder.
interface sklansky_pipe_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output in_valid, A, B, Cin, mode, out_ready,
        input  in_ready, out_valid, Sum, Cout
    );

    modport slave (
        input  in_valid, A, B, Cin, mode, out_ready,
        output in_ready, out_valid, Sum, Cout
    );
endinterface

// File: rtl/sklansky_pipe_adder_prefix_level.sv
// One combinational Sklansky level: bits in the upper half of each 2^(LEVEL+1) block
// merge with the top bit of the lower half.
module sklansky_prefix_level #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEVEL = 0
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> LEVEL) & 1) == 1) begin : g_merge
            localparam int unsigned J = ((i >> LEVEL) << LEVEL) - 1;
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[J]);
            assign p_o[i] = p_i[i] & p_i[J];
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end
endmodule

// File: rtl/sklansky_pipe_adder.sv
// Pipelined Sklansky prefix adder with valid/ready flow control and an optional
// approximate low-bit mode selected per transfer.
module sklansky_pipe_adder
    import sklansky_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PIPE     = 2,
    parameter int unsigned APPROX_K = 4
) (
    input logic                 clk,
    input logic                 rst,
    sklansky_pipe_adder_if.slave bus
);
    localparam int unsigned LEVELS = clog2_levels(WIDTH);
    localparam logic [WIDTH-1:0] LoMask  = {WIDTH{1'b1}} >> (WIDTH - APPROX_K);
    localparam logic [WIDTH-1:0] KeepBit = LoMask ^ (LoMask >> 1);

    logic             approx;
    logic [WIDTH-1:0] g_pre, p_pre, h_pre;
    logic             c_pre;

    assign approx = (bus.mode == MODE_APPROX) && (APPROX_K != 0);

    // Mode is folded into g/p/h here, so it travels with the operands from acceptance on.
    always_comb begin
        c_pre = approx ? 1'b0 : bus.Cin;
        g_pre = bus.A & bus.B;
        p_pre = bus.A ^ bus.B;
        h_pre = p_pre;
        if (approx) begin
            g_pre = g_pre & (~LoMask | KeepBit);
            p_pre = p_pre & ~LoMask;
            h_pre = (h_pre & ~LoMask) | ((bus.A | bus.B) & LoMask);
        end
        g_pre[0] = g_pre[0] | (p_pre[0] & c_pre);
    end

    logic out_valid_q, cout_q, out_rdy;
    logic [WIDTH-1:0] sum_q;

    assign out_rdy = !out_valid_q || bus.out_ready;

    for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
        logic [WIDTH-1:0] g_in, p_in, h_in, g_c, p_c, g_o, p_o, h_o;
        logic             c_in, v_in, c_o, v_o, rdy_in, rdy_out;

        if (i == 0) begin : g_src
            assign g_in = g_pre;
            assign p_in = p_pre;
            assign h_in = h_pre;
            assign c_in = c_pre;
            assign v_in = bus.in_valid && !rst;
        end else begin : g_src
            assign g_in = g_lvl[i-1].g_o;
            assign p_in = g_lvl[i-1].p_o;
            assign h_in = g_lvl[i-1].h_o;
            assign c_in = g_lvl[i-1].c_o;
            assign v_in = g_lvl[i-1].v_o;
        end

        if (i == LEVELS - 1) begin : g_sink
            assign rdy_out = out_rdy;
        end else begin : g_sink
            assign rdy_out = g_lvl[i+1].rdy_in;
        end

        sklansky_prefix_level #(
            .WIDTH(WIDTH),
            .LEVEL(i)
        ) u_level (
            .g_i(g_in),
            .p_i(p_in),
            .g_o(g_c),
            .p_o(p_c)
        );

        if (stage_flag(i, PIPE, LEVELS)) begin : g_reg
            logic             v_q, v_d, c_q;
            logic [WIDTH-1:0] g_q, p_q, h_q;

            assign rdy_in = !v_q || rdy_out;
            assign v_d    = rdy_in ? v_in : v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else begin
                    v_q <= v_d;
                end
            end

            always_ff @(posedge clk) begin
                if (rdy_in && v_in) begin
                    g_q <= g_c;
                    p_q <= p_c;
                    h_q <= h_in;
                    c_q <= c_in;
                end
            end

            assign v_o = v_q;
            assign g_o = g_q;
            assign p_o = p_q;
            assign h_o = h_q;
            assign c_o = c_q;
        end else begin : g_comb
            assign rdy_in = rdy_out;
            assign v_o    = v_in;
            assign g_o    = g_c;
            assign p_o    = p_c;
            assign h_o    = h_in;
            assign c_o    = c_in;
        end
    end

    logic [WIDTH-1:0] g_fin, h_fin, sum_d;
    logic             c_fin, v_fin, cout_d, unused_p_fin;

    assign g_fin        = g_lvl[LEVELS-1].g_o;
    assign h_fin        = g_lvl[LEVELS-1].h_o;
    assign c_fin        = g_lvl[LEVELS-1].c_o;
    assign v_fin        = g_lvl[LEVELS-1].v_o;
    assign unused_p_fin = ^g_lvl[LEVELS-1].p_o;

    // After the tree, g_fin[i] is the carry out of bits [i:0] including carry-in.
    assign sum_d  = h_fin ^ {g_fin[WIDTH-2:0], c_fin};
    assign cout_d = g_fin[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (out_rdy) begin
            out_valid_q <= v_fin;
            if (v_fin) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign bus.in_ready  = g_lvl[0].rdy_in && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Bench: directed cases on a 16-bit/2-stage adder plus randomized streams on six
// width/depth configurations, all checked against an arithmetic model.
module tb_sklansky_pipe_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_rnd;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // {Cout,Sum} straight from the arithmetic definition of each mode.
    function automatic logic [63:0] model(input int unsigned w, input int unsigned k,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic md);
        logic [63:0] am, bm, lo, r;
        am = 64'(a);
        bm = 64'(b);
        if (md && k > 0) begin
            lo = (am | bm) & ((64'd1 << k) - 64'd1);
            r  = (((am >> k) + (bm >> k) + 64'(a[k-1] & b[k-1])) << k) | lo;
        end else begin
            r = am + bm + 64'(cin);
        end
        return r & ((64'd1 << (w + 1)) - 64'd1);
    endfunction

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        md;
        logic [63:0] exp;
    } vec_t;

    vec_t vq[$];

    sklansky_pipe_adder_if #(.WIDTH(16)) dut_if ();

    sklansky_pipe_adder #(
        .WIDTH(16),
        .PIPE(2),
        .APPROX_K(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dut_if)
    );

    task automatic add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic md, input logic [63:0] exp);
        vq.push_back('{a, b, cin, md, exp});
    endtask

    task automatic drive(input int idx);
        dut_if.A    = vq[idx].a;
        dut_if.B    = vq[idx].b;
        dut_if.Cin  = vq[idx].cin;
        dut_if.mode = vq[idx].md;
    endtask

    function automatic logic [63:0] res();
        return 64'({dut_if.Cout, dut_if.Sum});
    endfunction

    // Back-to-back stream from an empty pipe with out_ready held high.
    task automatic stream();
        int n;
        int sent;
        n    = vq.size();
        sent = 0;
        dut_if.out_ready = 1'b1;
        for (int c = 0; c < n + 4; c++) begin
            @(posedge clk);
            #1;
            dut_if.in_valid = (sent < n);
            if (sent < n) drive(sent);
            #1;
            if (sent < n) begin
                check("stream_in_ready", 64'(dut_if.in_ready), 64'd1);
                sent++;
            end
            check("stream_out_valid", 64'(dut_if.out_valid), 64'(c >= 2 && c < n + 2));
            if (c >= 2 && c < n + 2) check("stream_result", res(), vq[c-2].exp);
        end
        dut_if.in_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        rst = 1'b1;
        rst_rnd = 1'b1;
        dut_if.in_valid  = 1'b1;
        dut_if.A         = 16'hFFFF;
        dut_if.B         = 16'hFFFF;
        dut_if.Cin       = 1'b1;
        dut_if.mode      = 1'b0;
        dut_if.out_ready = 1'b1;

        check("pin_approx", model(16, 4, 32'h000F, 32'h0001, 1'b1, 1'b1), 64'h0000F);
        check("pin_exact", model(16, 4, 32'h000F, 32'h0001, 1'b1, 1'b0), 64'h00011);
        check("pin_wrap", model(16, 0, 32'hFFFF, 32'h0000, 1'b1, 1'b1), 64'h10000);
        check("pin_k2", model(8, 2, 32'h03, 32'h03, 1'b0, 1'b1), 64'h007);

        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("rst_result", res(), 64'd0);
        check("rst_in_ready", 64'(dut_if.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rst_rnd = 1'b0;
        dut_if.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("post_rst_idle", 64'(dut_if.out_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        vq.delete();
        add(16'hAAEA, 16'h4D55, 1'b0, 1'b0, 64'h0F83F);
        add(16'hF0F0, 16'h0F0F, 1'b1, 1'b0, 64'h10000);
        add(16'hCCCD, 16'h3B33, 1'b0, 1'b0, 64'h10800);
        add(16'hFFFF, 16'h4490, 1'b1, 1'b0, 64'h14490);
        stream();

        vq.delete();
        add(16'h000F, 16'h0001, 1'b1, 1'b1, 64'h0000F);
        add(16'h000F, 16'h0001, 1'b1, 1'b0, 64'h00011);
        add(16'h00F7, 16'h0019, 1'b0, 1'b1, 64'h0010F);
        add(16'h00F7, 16'h0019, 1'b0, 1'b0, 64'h00110);
        add(16'h0008, 16'h0008, 1'b1, 1'b1, 64'h00018);
        stream();

        // Backpressure: output stalled for 5 cycles while 3 transfers are offered.
        vq.delete();
        add(16'h1234, 16'h1111, 1'b0, 1'b0, 64'h02345);
        add(16'hFFFF, 16'h0001, 1'b0, 1'b0, 64'h10000);
        add(16'h8000, 16'h8000, 1'b1, 1'b0, 64'h10001);
        sent = 0;
        got  = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            dut_if.out_ready = (c >= 5);
            dut_if.in_valid  = (sent < 3);
            if (sent < 3) drive(sent);
            #1;
            if (c < 2) check("bp_accept", 64'(dut_if.in_ready), 64'd1);
            if (c >= 2 && c < 5) begin
                check("bp_in_ready_low", 64'(dut_if.in_ready), 64'd0);
                check("bp_hold_valid", 64'(dut_if.out_valid), 64'd1);
                check("bp_hold_result", res(), vq[0].exp);
            end
            if (dut_if.in_valid && dut_if.in_ready) sent++;
            if (dut_if.out_valid && dut_if.out_ready) begin
                if (got < 3) check("bp_order", res(), vq[got].exp);
                got++;
            end
        end
        dut_if.in_valid = 1'b0;
        check("bp_sent", 64'(sent), 64'd3);
        check("bp_got", 64'(got), 64'd3);

        // Reset with two results in flight.
        vq.delete();
        add(16'h0101, 16'h0202, 1'b0, 1'b0, 64'h00303);
        add(16'h1000, 16'h2000, 1'b1, 1'b0, 64'h03001);
        add(16'h7777, 16'h7777, 1'b0, 1'b0, 64'h0EEEE);
        add(16'h5A5A, 16'hA5A5, 1'b1, 1'b0, 64'h10000);
        dut_if.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            dut_if.in_valid = 1'b1;
            drive(c);
            #1;
            check("mid_accept", 64'(dut_if.in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(2);
        #1;
        check("mid_rst_in_ready", 64'(dut_if.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(dut_if.out_valid), 64'd0);
        check("mid_rst_result", res(), 64'd0);
        @(posedge clk);
        #1;
        dut_if.in_valid = 1'b1;
        drive(3);
        #1;
        check("mid_next_accept", 64'(dut_if.in_ready), 64'd1);
        @(posedge clk);
        #1;
        dut_if.in_valid = 1'b0;
        #1;
        check("mid_no_ghost", 64'(dut_if.out_valid), 64'd0);
        @(posedge clk);
        #2;
        check("mid_next_valid", 64'(dut_if.out_valid), 64'd1);
        check("mid_next_result", res(), vq[3].exp);
        @(posedge clk);
        #2;
        check("mid_single", 64'(dut_if.out_valid), 64'd0);

        for (int i = 0; i < 70000 && n_done < 6; i++) @(posedge clk);
        check("rnd_all_done", 64'(n_done), 64'd6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    for (genvar cfg = 0; cfg < 6; cfg++) begin : g_rnd
        localparam int unsigned W = (cfg < 2) ? 8 : (cfg < 4) ? 16 : 32;
        localparam int unsigned L = $clog2(W);
        localparam int unsigned P = (cfg % 2 == 0) ? 1 : L + 1;
        localparam int unsigned K = (cfg == 0) ? 0 : (cfg == 5) ? W - 1 : W / 4;
        localparam int unsigned N = 10000;

        sklansky_pipe_adder_if #(.WIDTH(W)) rif ();

        sklansky_pipe_adder #(
            .WIDTH(W),
            .PIPE(P),
            .APPROX_K(K)
        ) u_dut (
            .clk(clk),
            .rst(rst_rnd),
            .bus(rif)
        );

        initial begin : drive_check
            logic [63:0] expq[$];
            logic [31:0] a, b;
            logic        cin, md, stalled;
            logic [63:0] held;
            int          sent, cyc;
            sent    = 0;
            cyc     = 0;
            stalled = 1'b0;
            held    = '0;
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b0;
            rif.A    = '0;
            rif.B    = '0;
            rif.Cin  = 1'b0;
            rif.mode = 1'b0;
            while (rst_rnd !== 1'b0) @(posedge clk);
            while ((sent < N || expq.size() > 0) && cyc < 60000) begin
                @(posedge clk);
                #1;
                cyc++;
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom);
                md  = 1'($urandom);
                rif.in_valid  = (sent < N) && ($urandom_range(3) != 0);
                rif.A         = a[W-1:0];
                rif.B         = b[W-1:0];
                rif.Cin       = cin;
                rif.mode      = md;
                rif.out_ready = ($urandom_range(3) != 0);
                #1;
                if (stalled) begin
                    check($sformatf("rnd%0d_hold_valid", cfg), 64'(rif.out_valid), 64'd1);
                    check($sformatf("rnd%0d_hold_data", cfg), 64'({rif.Cout, rif.Sum}), held);
                end
                if (rif.in_valid && rif.in_ready) begin
                    expq.push_back(model(W, K, 32'(rif.A), 32'(rif.B), cin, md));
                    sent++;
                end
                if (rif.out_valid && rif.out_ready) begin
                    if (expq.size() == 0) begin
                        check($sformatf("rnd%0d_spurious", cfg), 64'(rif.out_valid), 64'd0);
                    end else begin
                        check($sformatf("rnd%0d_result", cfg), 64'({rif.Cout, rif.Sum}),
                              expq.pop_front());
                    end
                end
                stalled = rif.out_valid && !rif.out_ready;
                held    = 64'({rif.Cout, rif.Sum});
            end
            rif.in_valid = 1'b0;
            check($sformatf("rnd%0d_sent", cfg), 64'(sent), 64'(N));
            check($sformatf("rnd%0d_drained", cfg), 64'(expq.size()), 64'd0);
            n_done++;
        end
    end
endmodule

// File: doc/sklansky_pipe_adder.md
SKLANSKY_PIPE_ADDER -- requirements
Module: sklansky_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand width in bits (power of two, 4..64).
REQ-002 SHALL have parameter PIPE, default 2, meaning the number of register stages (1..LEVELS+1, LEVELS = clog2(WIDTH)).
REQ-003 SHALL have parameter APPROX_K, default 4, meaning the number of LSBs approximated in approximate mode (0..WIDTH-1).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning the operands are offered.
REQ-007 SHALL have port in_ready, output, 1 bit, meaning the operands are accepted this cycle.
REQ-008 SHALL have port A, input, WIDTH bits, the first operand.
REQ-009 SHALL have port B, input, WIDTH bits, the second operand.
REQ-010 SHALL have port Cin, input, 1 bit, the carry-in.
REQ-011 SHALL have port mode, input, 1 bit: 0 = exact, 1 = approximate.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning downstream accepts the result.
REQ-014 SHALL have port Sum, output, WIDTH bits, the sum.
REQ-015 SHALL have port Cout, output, 1 bit, the carry out of the MSB.

Function
REQ-016 SHALL accept a transfer when in_valid && in_ready, and SHALL deliver it when out_valid && out_ready.
REQ-017 SHALL compute, in exact mode, {Cout,Sum} = A + B + Cin modulo 2^(WIDTH+1) using a Sklansky (divide-and-conquer) prefix tree of LEVELS generate/propagate levels.
REQ-018 SHALL compute, in approximate mode, Sum[APPROX_K-1:0] = A|B over those bits, ignore Cin, and take the carry into bit APPROX_K as A[APPROX_K-1]&B[APPROX_K-1]; the upper bits SHALL be exact from that carry; APPROX_K = 0 SHALL make mode a no-op.
REQ-019 SHALL sample mode with the operands and carry it through the pipeline with the data.
REQ-020 SHALL have a latency of exactly PIPE cycles from acceptance to out_valid, with no stalls.
REQ-021 SHALL spread the PIPE register stages as evenly as possible over the LEVELS prefix levels plus the final sum XOR, with the last stage driving the outputs directly.
REQ-022 SHALL sustain one result per cycle while out_ready = 1.
REQ-023 SHALL hold each stage while it is valid and the stage downstream of it is stalled.
REQ-024 SHALL let an empty stage (a bubble) fill even when the output is stalled.
REQ-025 SHALL drive in_ready = !stage1_valid || stage1_advances (combinational, no combinational path from in_valid).
REQ-026 SHALL keep Sum, Cout and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-027 SHALL, when the pipeline is full and out_ready = 0, drive in_ready = 0 and drop or overwrite no transfer.
REQ-028 SHALL, on the all-ones wrap (A+B+Cin = 2^WIDTH), produce Sum = 0 and Cout = 1.

Reset
REQ-029 SHALL, while rst = 1, clear every stage valid bit and set out_valid = 0, Sum = 0, Cout = 0.
REQ-030 SHALL drive in_ready = 0 while rst = 1, and rst SHALL take priority over a simultaneous in_valid.
REQ-031 SHALL discard all in-flight results on a mid-operation reset; the first result after reset SHALL come from the first post-reset acceptance.
REQ-032 SHALL leave data registers other than the outputs without reset.

Structure
REQ-033 SHALL place in a shared package sklansky_pkg: the LEVELS/clog2 helper function, the mode encoding constants (MODE_EXACT = 0, MODE_APPROX = 1), and the stage-placement function mapping a level index to its register flag.
REQ-034 SHALL implement one prefix level as sub-module sklansky_prefix_level, parameterised by WIDTH and level index, purely combinational, and instantiated LEVELS times.

Verification (WIDTH=16, PIPE=2, APPROX_K=4, mode=0 unless stated)
REQ-035 SHALL cover back-to-back streaming with out_ready = 1 of: A=0xAAEA, B=0x4D55, Cin=0 -> Sum=0xF83F, Cout=0; then A=0xF0F0, B=0x0F0F, Cin=1 -> Sum=0x0000, Cout=1; then A=0xCCCD, B=0x3B33, Cin=0 -> Sum=0x0800, Cout=1; then A=0xFFFF, B=0x4490, Cin=1 -> Sum=0x4490, Cout=1; each result 2 cycles after acceptance, one per cycle.
REQ-036 SHALL cover per-transfer mode: A=0x000F, B=0x0001, Cin=1 -> mode=1 gives Sum=0x000F, Cout=0; mode=0 gives Sum=0x0011; transfers with alternating mode SHALL each use their own mode.
REQ-037 SHALL cover backpressure: out_ready = 0 for 5 cycles with 3 offers -> in_ready falls after 2 accepts, the output stays stable, and on release the results appear in order with none lost.
REQ-038 SHALL cover reset mid-stream: rst = 1 for 1 cycle with 2 results in flight -> out_valid = 0 next cycle, the in-flight results are never emitted, and the next acceptance yields the correct result.
REQ-039 SHALL cover random regression over WIDTH in {8,16,32} x PIPE in {1, LEVELS+1}: 10k random transfers with random valid/ready against a reference model -> zero mismatches, in order.
